// File: rtl/lfsr_burst_sequencer.sv
// lfsr_burst_sequencer: seeds and steps an external LFSR, streaming decimated bursts of its states
module lfsr_burst_sequencer #(
   parameter int NUM_BITS = 16,
   parameter int LEN_BITS = 16,
   parameter int DEC_BITS = 8
) (
   input  logic                i_Clk,
   input  logic                i_Rst_n,
   input  logic                i_Start,
   input  logic                i_Abort,
   input  logic [NUM_BITS-1:0] i_Seed,
   input  logic [LEN_BITS-1:0] i_Burst_Len,
   input  logic [DEC_BITS-1:0] i_Decim,
   output logic                o_Lfsr_Enable,
   output logic                o_Lfsr_Seed_DV,
   output logic [NUM_BITS-1:0] o_Lfsr_Seed_Data,
   input  logic [NUM_BITS-1:0] i_Lfsr_Data,
   output logic [NUM_BITS-1:0] o_Data,
   output logic                o_Valid,
   input  logic                i_Ready,
   output logic                o_Busy,
   output logic                o_Wrap,
   output logic                o_Done
);
   typedef enum logic [2:0] {IDLE, SEED, RUN, HOLD, DONE} state_t;
   state_t state_q, state_d;
   logic [NUM_BITS-1:0] seed_q, seed_d, data_q, data_d;
   logic [LEN_BITS-1:0] len_q, len_d, word_cnt_q, word_cnt_d;
   logic [DEC_BITS-1:0] decim_q, decim_d, dec_cnt_q, dec_cnt_d;
   logic valid_q, valid_d, wrap_q, wrap_d;
   logic last, xfer, stalled, due, capture, abort;
   assign last    = word_cnt_q == len_q;
   assign xfer    = valid_q && i_Ready;
   assign stalled = valid_q && !i_Ready;
   assign abort   = i_Abort && state_q != IDLE;
   assign due     = state_q == RUN && dec_cnt_q == '0 && !last;
   assign capture = due && !stalled && !i_Abort;
   assign o_Lfsr_Seed_Data = seed_q;
   assign o_Data  = data_q;
   assign o_Valid = valid_q;
   assign o_Wrap  = wrap_q;
   // state register
   always_ff @(posedge i_Clk or negedge i_Rst_n)
      if (!i_Rst_n) state_q <= IDLE;
      else state_q <= state_d;
   // next state; an abort pulls every busy state back to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (i_Start) state_d = (i_Burst_Len != '0) ? SEED : DONE;
         SEED: state_d = RUN;
         RUN:  if (last && xfer) state_d = DONE; else if (due && stalled) state_d = HOLD;
         HOLD: if (i_Ready) state_d = RUN;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end
   // LFSR control and status; the LFSR freezes while a due capture is blocked or after the last capture
   always_comb begin
      o_Lfsr_Seed_DV = state_q == SEED && !i_Abort;
      o_Lfsr_Enable  = !i_Abort && (state_q == SEED || (state_q == RUN && !last && !(due && stalled)));
      o_Busy         = state_q == SEED || state_q == RUN || state_q == HOLD;
      o_Done         = state_q == DONE && !i_Abort;
   end
   // datapath next state: latch config, count decimation steps, capture words
   always_comb begin
      seed_d     = seed_q;
      len_d      = len_q;
      decim_d    = decim_q;
      data_d     = data_q;
      word_cnt_d = word_cnt_q;
      dec_cnt_d  = dec_cnt_q;
      valid_d    = valid_q && !xfer;
      wrap_d     = capture && word_cnt_q != '0 && i_Lfsr_Data == seed_q;
      if (state_q == IDLE && i_Start) begin
         seed_d  = i_Seed;
         len_d   = i_Burst_Len;
         decim_d = i_Decim;
      end
      if (state_q == SEED) begin
         dec_cnt_d  = decim_q;
         word_cnt_d = '0;
      end
      if (capture) begin
         data_d     = i_Lfsr_Data;
         valid_d    = 1'b1;
         word_cnt_d = word_cnt_q + 1'b1;
         dec_cnt_d  = decim_q;
      end else if (state_q == RUN && dec_cnt_q != '0 && !last && !i_Abort) begin
         dec_cnt_d = dec_cnt_q - 1'b1;
      end
      if (abort) valid_d = 1'b0;
   end
   // datapath registers
   always_ff @(posedge i_Clk or negedge i_Rst_n)
      if (!i_Rst_n) begin
         seed_q     <= '0;
         len_q      <= '0;
         decim_q    <= '0;
         data_q     <= '0;
         word_cnt_q <= '0;
         dec_cnt_q  <= '0;
         valid_q    <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         seed_q     <= seed_d;
         len_q      <= len_d;
         decim_q    <= decim_d;
         data_q     <= data_d;
         word_cnt_q <= word_cnt_d;
         dec_cnt_q  <= dec_cnt_d;
         valid_q    <= valid_d;
         wrap_q     <= wrap_d;
      end
endmodule
